instr_encoder: RTL

- Converts mnemonic-level instruction requests (mnemonic code plus register/immediate fields) into 32-bit MIPS instruction words.
- Streams the encoded words, each tagged with a sequential word address, toward instruction memory or a test loader. It is the encoding counterpart of the core's opcode/funct decode.
- Valid/ready handshake on both sides; encoded words are buffered in an internal FIFO.
- Unsupported mnemonics are consumed, dropped and reported.

---
 rtl/instr_encoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns mnemonic requests into 32-bit words and
// streams them, each tagged with a sequential word address, through a small FIFO.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_mn,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_addr  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   addr_cnt;

  logic          supported;
  logic          accept;
  logic          push;
  logic          pop;
  logic          bad_accept;

  fmt_t          enc_fmt;
  logic [5:0]    enc_op;
  logic [5:0]    enc_fn;
  logic [4:0]    enc_rs;
  logic [4:0]    enc_rt;
  logic [31:0]   enc_word;

  // Requests are refused outright while reset or restart is asserted.
  assign in_ready   = rst_n && !restart && (count < CW'(DEPTH));
  assign supported  = (in_mn < 6'd27);
  assign accept     = in_valid && in_ready;
  assign push       = accept && supported;
  assign bad_accept = accept && !supported;
  assign pop        = out_ready && (count != '0);

  assign out_valid  = (count != '0);
  assign out_instr  = out_valid ? mem_instr[rd_ptr] : 32'h0;
  assign out_addr   = out_valid ? mem_addr[rd_ptr]  : 32'h0;

  always_comb begin
    enc_fmt = FMT_I;
    enc_op  = 6'h00;
    enc_fn  = 6'h00;
    enc_rs  = in_rs;
    enc_rt  = in_rt;
    case (in_mn)
      6'd0:  begin enc_fmt = FMT_R; enc_fn = 6'h21; end
      6'd1:  begin enc_fmt = FMT_R; enc_fn = 6'h24; end
      6'd2:  begin enc_fmt = FMT_R; enc_fn = 6'h27; end
      6'd3:  begin enc_fmt = FMT_R; enc_fn = 6'h25; end
      6'd4:  begin enc_fmt = FMT_R; enc_fn = 6'h23; end
      6'd5:  begin enc_fmt = FMT_R; enc_fn = 6'h26; end
      6'd6:  begin enc_fmt = FMT_R; enc_fn = 6'h2A; end
      6'd7:  begin enc_fmt = FMT_R; enc_fn = 6'h2B; end
      6'd8:  begin enc_fmt = FMT_R; enc_fn = 6'h20; end
      6'd9:  enc_op = 6'h09;
      6'd10: enc_op = 6'h0C;
      6'd11: enc_op = 6'h0D;
      6'd12: enc_op = 6'h0E;
      6'd13: begin enc_op = 6'h0F; enc_rs = 5'd0; end
      6'd14: enc_op = 6'h0A;
      6'd15: enc_op = 6'h0B;
      6'd16: enc_op = 6'h08;
      // CLO/CLZ use the R layout under SPECIAL2 and repeat rd in the rt slot
      6'd17: begin enc_fmt = FMT_R; enc_op = 6'h1C; enc_fn = 6'h21; enc_rt = in_rd; end
      6'd18: begin enc_fmt = FMT_R; enc_op = 6'h1C; enc_fn = 6'h20; enc_rt = in_rd; end
      6'd19: enc_op = 6'h04;
      6'd20: enc_op = 6'h05;
      6'd21: begin enc_op = 6'h07; enc_rt = 5'd0; end
      6'd22: begin enc_op = 6'h06; enc_rt = 5'd0; end
      6'd23: begin enc_op = 6'h01; enc_rt = 5'd0; end
      6'd24: begin enc_fmt = FMT_J; enc_op = 6'h02; end
      6'd25: enc_op = 6'h23;
      6'd26: enc_op = 6'h2B;
      default: ;
    endcase
  end

  always_comb begin
    enc_word = 32'h0;
    case (enc_fmt)
      FMT_R:   enc_word = {enc_op, enc_rs, enc_rt, in_rd, 5'b0, enc_fn};
      FMT_I:   enc_word = {enc_op, enc_rs, enc_rt, in_imm[15:0]};
      FMT_J:   enc_word = {enc_op, in_imm};
      default: enc_word = 32'h0;
    endcase
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= enc_word;
      mem_addr[wr_ptr]  <= addr_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
      err      <= 1'b0;
    end else begin
      err <= bad_accept;
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        addr_cnt <= addr_cnt + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Only a true reset clears the error tally; restart leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (bad_accept && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule
